// File: rtl/light_stand_fsm_pkg.sv
// Light stand shared definitions: state codes and level count.
// Shared by the brightness FSM, the comparator and the PWM counter.
package light_stand_fsm_pkg;

  localparam int STATE_W    = 3;
  localparam int NUM_LEVELS = 5;

  typedef enum logic [STATE_W-1:0] {
    S_OFF = 3'd0,
    S_30  = 3'd1,
    S_60  = 3'd2,
    S_80  = 3'd3,
    S_99  = 3'd4
  } state_t;

  function automatic logic is_legal(state_t s);
    return 32'(s) < NUM_LEVELS;
  endfunction

  function automatic state_t next_level(state_t s);
    state_t n;
    case (s)
      S_OFF:   n = S_30;
      S_30:    n = S_60;
      S_60:    n = S_80;
      S_80:    n = S_99;
      default: n = S_OFF;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/light_stand_fsm_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and
// a one-cycle registered pulse on each accepted press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_btn,
  output logic o_press
);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             press_q;
  logic [CNT_W-1:0] cnt;
  logic             differs;
  logic             moving;
  logic             accept;

  assign differs = sync2 != stable;
  assign moving  = sync1 != sync2;
  assign accept  = differs && !moving &&
                   (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      stable  <= 1'b0;
      press_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= i_btn;
      sync2   <= sync1;
      press_q <= accept && sync2;
      // Any movement of the synchronised level restarts the window
      if (!differs || moving) begin
        cnt <= '0;
      end else if (accept) begin
        cnt    <= '0;
        stable <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign o_press = press_q;

endmodule

// File: rtl/light_stand_fsm.sv
// Light stand brightness controller: two debounced buttons drive a
// five-level state machine that picks one comparator PWM output.
import light_stand_fsm_pkg::*;

module light_stand_fsm #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_btn_mode,
  input  logic       i_btn_off,
  input  logic       i_light_0,
  input  logic       i_light_1,
  input  logic       i_light_2,
  input  logic       i_light_3,
  input  logic       i_light_4,
  output logic       o_led,
  output logic [2:0] o_state
);

  state_t state;
  state_t state_nx;
  logic   mode_press;
  logic   off_press;
  logic   led_sel;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_mode (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_btn    (i_btn_mode),
    .o_press  (mode_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_off (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_btn    (i_btn_off),
    .o_press  (off_press)
  );

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      off_press:               state_nx = S_OFF;
      mode_press & ~off_press: state_nx = next_level(state);
      default: begin
        if (!is_legal(state)) state_nx = S_OFF;
      end
    endcase
  end

  always_comb begin
    led_sel = 1'b0;
    case (state)
      S_OFF:   led_sel = i_light_0;
      S_30:    led_sel = i_light_1;
      S_60:    led_sel = i_light_2;
      S_80:    led_sel = i_light_3;
      S_99:    led_sel = i_light_4;
      default: led_sel = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= S_OFF;
      o_led <= 1'b0;
    end else begin
      state <= state_nx;
      o_led <= led_sel;
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_light_stand_fsm.sv
// Bench for light_stand_fsm: directed button sequences with random
// PWM light levels, checked against a counting brightness model.
module tb_light_stand_fsm;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_mode;
  logic       btn_off;
  logic [4:0] lt;
  logic       led;
  logic [2:0] st;

  int total = 0;
  int bad   = 0;
  int lvl   = 0;

  always #5 clk = ~clk;

  light_stand_fsm #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (3)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_btn_mode(btn_mode),
    .i_btn_off (btn_off),
    .i_light_0 (lt[0]),
    .i_light_1 (lt[1]),
    .i_light_2 (lt[2]),
    .i_light_3 (lt[3]),
    .i_light_4 (lt[4]),
    .o_led     (led),
    .o_state   (st)
  );

  task automatic chk(string tag, logic [2:0] got, logic [2:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    lt = 5'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(string tag);
    chk({tag, "_state"}, st, 3'(lvl));
    chk({tag, "_led"}, 3'(led), 3'(lt[lvl]));
  endtask

  task automatic press(bit m, bit o, int hold);
    btn_mode = m;
    btn_off  = o;
    repeat (hold) tick();
    btn_mode = 1'b0;
    btn_off  = 1'b0;
    repeat (DC + 6) tick();
  endtask

  initial begin
    int old;
    int kind;
    int hold;
    rst_n    = 1'b0;
    btn_mode = 1'b0;
    btn_off  = 1'b0;
    lt       = '1;

    // reset with all lights high
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", st, 3'd0);
    chk("rst_led", 3'(led), 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    check_out("post_rst");

    // mode cycling
    for (int i = 0; i < 6; i++) begin
      press(1'b1, 1'b0, 10);
      lvl = (lvl + 1) % 5;
      check_out($sformatf("cycle%0d", i));
    end

    // bounce then clean hold
    old = lvl;
    for (int i = 0; i < 4; i++) begin
      btn_mode = (i % 2 == 0);
      tick();
    end
    btn_mode = 1'b0;
    repeat (DC + 6) tick();
    check_out("bounce");
    press(1'b1, 1'b0, 6);
    lvl = (old + 1) % 5;
    check_out("hold6");

    // off wins over mode
    while (lvl != 3) begin
      press(1'b1, 1'b0, 8);
      lvl = (lvl + 1) % 5;
    end
    check_out("at80");
    press(1'b1, 1'b1, 10);
    lvl = 0;
    check_out("both");
    press(1'b0, 1'b1, 8);
    check_out("off_in_off");

    // press-to-output latency
    old = lvl;
    tick();
    btn_mode = 1'b1;
    repeat (6) tick();
    chk("lat_t6_state", st, 3'(old));
    tick();
    lvl = (old + 1) % 5;
    chk("lat_t7_state", st, 3'(lvl));
    chk("lat_t7_led", 3'(led), 3'(lt[old]));
    tick();
    chk("lat_t8_led", 3'(led), 3'(lt[lvl]));
    btn_mode = 1'b0;
    repeat (DC + 6) tick();
    check_out("lat_settle");

    // reset in the middle of a debounce
    while (lvl != 2) begin
      press(1'b1, 1'b0, 8);
      lvl = (lvl + 1) % 5;
    end
    check_out("at60");
    btn_mode = 1'b1;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_state", st, 3'd0);
    chk("midrst_led", 3'(led), 3'd0);
    lvl = 0;
    repeat (2) tick();
    btn_mode = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (DC + 6) tick();
    check_out("after_rst");

    // random press sequence
    for (int i = 0; i < 20; i++) begin
      kind = $urandom_range(0, 3);
      hold = $urandom_range(6, 12);
      press(kind != 3, kind == 3, hold);
      lvl = (kind == 3) ? 0 : (lvl + 1) % 5;
      check_out($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
